// File: rtl/line_buffer_3row.sv
// Three-row line buffer: aligns rows y-2, y-1, y per column for a 3x3 window stage.
// Optional top-edge replication is built when LINEBUF_BORDER_REP_EN is defined.
module line_buffer_3row #(
  parameter int WIDTH     = 24,
  parameter int PIC_WIDTH = 480,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             sof,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3
);

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(PIC_WIDTH - 1);

  logic [WIDTH-1:0] mem_a [PIC_WIDTH];
  logic [WIDTH-1:0] mem_b [PIC_WIDTH];

  logic [CNT_W-1:0] col_cnt, col;
  logic [1:0]       row_cnt, row;
  logic [WIDTH-1:0] rd_a, rd_b;

  // sof forces this pixel to (0,0) regardless of counter state
  assign col  = sof ? '0 : col_cnt;
  assign row  = sof ? '0 : row_cnt;
  assign rd_a = mem_a[col];
  assign rd_b = mem_b[col];

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (valid_in) begin
      if (col == LAST_COL) begin
        col_cnt <= '0;
        row_cnt <= (row == 2'd2) ? 2'd2 : row + 2'd1;
      end else begin
        col_cnt <= col + 1'b1;
        row_cnt <= row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      dout1     <= '0;
      dout2     <= '0;
      dout3     <= '0;
    end else begin
`ifdef LINEBUF_BORDER_REP_EN
      valid_out <= valid_in;
`else
      valid_out <= valid_in & (row == 2'd2);
`endif
      if (valid_in) begin
        dout3 <= din;
`ifdef LINEBUF_BORDER_REP_EN
        case (row)
          2'd0:    begin dout1 <= din;  dout2 <= din;  end
          2'd1:    begin dout1 <= rd_a; dout2 <= rd_a; end
          default: begin dout1 <= rd_b; dout2 <= rd_a; end
        endcase
`else
        dout1 <= rd_b;
        dout2 <= rd_a;
`endif
      end
    end
  end

  // memories are never cleared; rows 0/1 gating hides stale contents
  always_ff @(posedge clk) begin
    if (!rst && valid_in) begin
      mem_b[col] <= rd_a;
      mem_a[col] <= din;
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row (PIC_WIDTH=4) against a frame-history reference model.
module tb_line_buffer_3row;
  localparam int W  = 24;
  localparam int PW = 4;

  logic         clk = 1'b0;
  logic         rst, valid_in, sof;
  logic [W-1:0] din;
  logic         valid_out;
  logic [W-1:0] dout1, dout2, dout3;

  int checks = 0;
  int errors = 0;

  line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sof(sof), .din(din),
    .valid_out(valid_out), .dout1(dout1), .dout2(dout2), .dout3(dout3)
  );

  always #5 clk = ~clk;

  // reference model: pixel history of the last three rows of the current frame
  logic [W-1:0] hist [3][PW];
  int           mrow = 0, mcol = 0;
  logic         ev = 1'b0;
  logic [W-1:0] e1 = '0, e2 = '0, e3 = '0;
  logic         k1 = 1'b0, k2 = 1'b0, k3 = 1'b0;

  task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    logic [W-1:0] up2, up1;
    rst = r; valid_in = v; sof = s; din = d;
    if (r) begin
      mrow = 0; mcol = 0; ev = 1'b0;
      e1 = '0; e2 = '0; e3 = '0; k1 = 1'b1; k2 = 1'b1; k3 = 1'b1;
    end else if (v) begin
      if (s) begin mrow = 0; mcol = 0; end
      up2 = hist[(mrow + 1) % 3][mcol];
      up1 = hist[(mrow + 2) % 3][mcol];
      e3 = d; k3 = 1'b1;
`ifdef LINEBUF_BORDER_REP_EN
      ev = 1'b1;
      if (mrow == 0)      begin e1 = d;   e2 = d;   k1 = 1'b1; k2 = 1'b1; end
      else if (mrow == 1) begin e1 = up1; e2 = up1; k1 = 1'b1; k2 = 1'b1; end
      else                begin e1 = up2; e2 = up1; k1 = 1'b1; k2 = 1'b1; end
`else
      ev = (mrow >= 2);
      if (mrow == 0)      begin k1 = 1'b0; k2 = 1'b0; end
      else if (mrow == 1) begin k1 = 1'b0; e2 = up1; k2 = 1'b1; end
      else                begin e1 = up2; e2 = up1; k1 = 1'b1; k2 = 1'b1; end
`endif
      hist[mrow % 3][mcol] = d;
      mcol++;
      if (mcol == PW) begin mcol = 0; mrow++; end
    end else begin
      ev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, W'($urandom));
      checks++;
      if (valid_out !== 1'b0 || dout1 !== '0 || dout2 !== '0 || dout3 !== '0) begin
        errors++;
        $display("FAIL reset cyc%0d v=%b d1=%h d2=%h d3=%h required all 0", i, valid_out, dout1, dout2, dout3);
      end
    end
    step(1'b0, 1'b1, 1'b0, 24'h00);
    checks++;
    if (valid_out !== ev || dout3 !== e3) begin
      errors++;
      $display("FAIL reset_release v=%b/%b d3=%h/%h", valid_out, ev, dout3, e3);
    end
  endtask

  task automatic test_stream();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < PW; c++) begin
        step(1'b0, 1'b1, (r == 0 && c == 0), W'(r * 16 + c));
        checks++;
        if (valid_out !== ev || (k1 && dout1 !== e1) || (k2 && dout2 !== e2) || dout3 !== e3) begin
          errors++;
          $display("FAIL stream r%0d c%0d v=%b/%b d1=%h/%h d2=%h/%h d3=%h/%h",
                   r, c, valid_out, ev, dout1, e1, dout2, e2, dout3, e3);
        end
`ifndef LINEBUF_BORDER_REP_EN
        if (r == 2 && c == 1) begin
          checks++;
          if (valid_out !== 1'b1 || dout1 !== 24'h01 || dout2 !== 24'h11 || dout3 !== 24'h21) begin
            errors++;
            $display("FAIL stream_r2c1 v=%b d1=%h d2=%h d3=%h required 1 01 11 21", valid_out, dout1, dout2, dout3);
          end
        end
`endif
      end
  endtask

  task automatic test_gaps();
    for (int c = 0; c < PW; c++) begin
      step(1'b0, 1'b1, 1'b0, W'(48 + c));
      checks++;
      if (valid_out !== ev || (k1 && dout1 !== e1) || (k2 && dout2 !== e2) || dout3 !== e3) begin
        errors++;
        $display("FAIL gaps_px c%0d v=%b/%b d1=%h/%h d2=%h/%h d3=%h/%h",
                 c, valid_out, ev, dout1, e1, dout2, e2, dout3, e3);
      end
      if (c == 3) begin
        checks++;
        if (dout1 !== 24'h13 || dout2 !== 24'h23 || dout3 !== 24'h33) begin
          errors++;
          $display("FAIL gaps_c3 d1=%h d2=%h d3=%h required 13 23 33", dout1, dout2, dout3);
        end
      end
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 1'b0, W'($urandom));
        checks++;
        if (valid_out !== 1'b0 || (k1 && dout1 !== e1) || (k2 && dout2 !== e2) || dout3 !== e3) begin
          errors++;
          $display("FAIL gaps_idle c%0d g%0d v=%b d1=%h/%h d2=%h/%h d3=%h/%h",
                   c, g, valid_out, dout1, e1, dout2, e2, dout3, e3);
        end
      end
    end
  endtask

  task automatic test_sof_abort();
    int first = 0;
    step(1'b0, 1'b1, 1'b0, 24'h40);
    step(1'b0, 1'b1, 1'b0, 24'h41);
    for (int n = 1; n <= 12; n++) begin
      step(1'b0, 1'b1, (n == 1), W'(24'h100 + n));
      checks++;
      if (valid_out !== ev || (k1 && dout1 !== e1) || (k2 && dout2 !== e2) || dout3 !== e3) begin
        errors++;
        $display("FAIL sof_abort n%0d v=%b/%b d1=%h/%h d2=%h/%h d3=%h/%h",
                 n, valid_out, ev, dout1, e1, dout2, e2, dout3, e3);
      end
      if (valid_out === 1'b1 && first == 0) first = n;
    end
`ifndef LINEBUF_BORDER_REP_EN
    checks++;
    if (first != 9) begin
      errors++;
      $display("FAIL sof_abort_first got pixel %0d required 9", first);
    end
`endif
  endtask

  task automatic test_rst_mid();
    int first = 0;
    for (int n = 0; n < 3 * PW + 1; n++) step(1'b0, 1'b1, (n == 0), W'($urandom));
    step(1'b1, 1'b0, 1'b0, '0);
    for (int n = 1; n <= 12; n++) begin
      step(1'b0, 1'b1, 1'b0, W'($urandom));
      checks++;
      if (valid_out !== ev || (k1 && dout1 !== e1) || (k2 && dout2 !== e2) || dout3 !== e3) begin
        errors++;
        $display("FAIL rst_mid n%0d v=%b/%b d1=%h/%h d2=%h/%h d3=%h/%h",
                 n, valid_out, ev, dout1, e1, dout2, e2, dout3, e3);
      end
      if (valid_out === 1'b1 && first == 0) first = n;
    end
`ifndef LINEBUF_BORDER_REP_EN
    checks++;
    if (first != 9) begin
      errors++;
      $display("FAIL rst_mid_first got pixel %0d required 9", first);
    end
`endif
  endtask

  task automatic test_border();
`ifdef LINEBUF_BORDER_REP_EN
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < PW; c++) begin
        step(1'b0, 1'b1, (r == 0 && c == 0), W'(r * 16 + c));
        if (c == 2) begin
          checks++;
          if (valid_out !== 1'b1 || dout1 !== 24'h02 || dout2 !== 24'h02 || dout3 !== W'(r * 16 + 2)) begin
            errors++;
            $display("FAIL border r%0d c2 v=%b d1=%h d2=%h d3=%h", r, valid_out, dout1, dout2, dout3);
          end
        end
      end
`endif
  endtask

  task automatic test_random();
    logic r, v, s;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 2) != 0);
      s = v && ($urandom_range(0, 59) == 0);
      step(r, v, s, W'($urandom));
      checks++;
      if (valid_out !== ev || (k1 && dout1 !== e1) || (k2 && dout2 !== e2) || (k3 && dout3 !== e3)) begin
        errors++;
        $display("FAIL random i%0d v=%b/%b d1=%h/%h d2=%h/%h d3=%h/%h",
                 i, valid_out, ev, dout1, e1, dout2, e2, dout3, e3);
      end
    end
  endtask

  initial begin
    rst = 1'b0; valid_in = 1'b0; sof = 1'b0; din = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_gaps();
    test_sof_abort();
    test_rst_mid();
    test_border();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
